ch_sel_seq: RTL and testbench

CH_SEL_SEQ -- requirements
Module: ch_sel_seq

---
 rtl/ch_sel_pkg.sv | 17 +
 rtl/ch_next_sel.sv | 28 ++
 rtl/ch_sel_seq.sv | 154 +++++++++++++++
 tb/tb_ch_sel_seq.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ch_sel_pkg.sv
// Shared types and helpers for the channel-select sequencer.
package ch_sel_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Select width for n channels; never below one bit.
  function automatic int clog2w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/ch_next_sel.sv
// Combinational priority finder: lowest set mask bit strictly above i_from.
// i_from is two's complement so that -1 (all ones) searches from bit 0.
module ch_next_sel #(
  parameter int NUM_CH = 4,
  parameter int SW     = 2
) (
  input  logic [NUM_CH-1:0] i_mask,
  input  logic [SW:0]       i_from,
  output logic [SW-1:0]     o_idx,
  output logic              o_none
);

  int w_from;

  // Scan from the top down so the last hit is the lowest qualifying bit.
  always_comb begin
    w_from = int'($signed(i_from));
    o_idx  = '0;
    o_none = 1'b1;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i_mask[i] && (i > w_from)) begin
        o_idx  = SW'(i);
        o_none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ch_sel_seq.sv
// Frame sequencer: on a strobe, snapshots all channel samples and the enable
// mask, then streams the enabled channels one word per clock in ascending order.
//
//   state | meaning
//   IDLE  | no frame in progress, strobe accepted
//   SCAN  | issuing snapshot[r_ptr]; strobe accepted only on the last channel
//
// Words pass through one internal stage (r_s1_*) and then the output
// registers, so the first word appears two edges after the accepting edge.
module ch_sel_seq
  import ch_sel_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int DW     = 16,
  localparam int SW     = clog2w(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 strobe,
  input  logic [NUM_CH-1:0]    ch_mask,
  input  logic [NUM_CH*DW-1:0] din,
  input  logic                 clr_ovf,
  output logic [SW-1:0]        sel,
  output logic [DW-1:0]        dout,
  output logic                 valid,
  output logic                 sof,
  output logic                 eof,
  output logic                 ovf
);

  state_t r_state, w_state_nxt;
  logic [SW-1:0]        r_ptr;
  logic [NUM_CH-1:0]    r_snap_mask;
  logic [NUM_CH*DW-1:0] r_snap_din;
  logic                 r_first;

  logic                 r_s1_valid, r_s1_sof, r_s1_eof;
  logic [SW-1:0]        r_s1_sel;
  logic [DW-1:0]        r_s1_dout;

  logic                 r_valid, r_sof, r_eof, r_ovf;
  logic [SW-1:0]        r_sel;
  logic [DW-1:0]        r_dout;

  logic [SW-1:0]        w_pre_idx, w_nxt_idx;
  logic                 w_pre_none, w_nxt_none;
  logic                 w_emit, w_last, w_win, w_load, w_ovr;
  logic [DW-1:0]        w_words [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_words
    assign w_words[i] = r_snap_din[i*DW +: DW];
  end

  ch_next_sel #(.NUM_CH(NUM_CH), .SW(SW)) u_pre (
    .i_mask (ch_mask),
    .i_from ('1),
    .o_idx  (w_pre_idx),
    .o_none (w_pre_none)
  );

  ch_next_sel #(.NUM_CH(NUM_CH), .SW(SW)) u_nxt (
    .i_mask (r_snap_mask),
    .i_from ({1'b0, r_ptr}),
    .o_idx  (w_nxt_idx),
    .o_none (w_nxt_none)
  );

  // Next state, strobe acceptance window and overrun detection.
  always_comb begin
    w_state_nxt = r_state;
    w_emit      = (r_state == SCAN);
    w_last      = w_emit && w_nxt_none;
    w_win       = (r_state == IDLE) || w_last;
    w_load      = strobe && w_win && !w_pre_none;
    w_ovr       = strobe && !w_win && (ch_mask != '0);
    case (r_state)
      IDLE: if (w_load) w_state_nxt = SCAN;
      SCAN: if (w_nxt_none && !w_load) w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Snapshot and pointer; a load on the last word wins over the advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr       <= '0;
      r_snap_mask <= '0;
      r_snap_din  <= '0;
      r_first     <= 1'b0;
    end else if (w_load) begin
      r_ptr       <= w_pre_idx;
      r_snap_mask <= ch_mask;
      r_snap_din  <= din;
      r_first     <= 1'b1;
    end else if (w_emit) begin
      if (!w_nxt_none) r_ptr <= w_nxt_idx;
      r_first <= 1'b0;
    end
  end

  // Internal word stage; idle cycles carry zeros.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_sel   <= '0;
      r_s1_dout  <= '0;
      r_s1_sof   <= 1'b0;
      r_s1_eof   <= 1'b0;
    end else begin
      r_s1_valid <= w_emit;
      r_s1_sel   <= w_emit ? r_ptr : '0;
      r_s1_dout  <= w_emit ? w_words[r_ptr] : '0;
      r_s1_sof   <= w_emit && r_first;
      r_s1_eof   <= w_last;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_sel   <= '0;
      r_dout  <= '0;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;
    end else begin
      r_valid <= r_s1_valid;
      r_sel   <= r_s1_sel;
      r_dout  <= r_s1_dout;
      r_sof   <= r_s1_sof;
      r_eof   <= r_s1_eof;
    end
  end

  // Sticky overrun; a new overrun beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset)        r_ovf <= 1'b0;
    else if (w_ovr)   r_ovf <= 1'b1;
    else if (clr_ovf) r_ovf <= 1'b0;
  end

  assign sel   = r_sel;
  assign dout  = r_dout;
  assign valid = r_valid;
  assign sof   = r_sof;
  assign eof   = r_eof;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_ch_sel_seq.sv
// Bench for ch_sel_seq: a 4-channel/16-bit and an 8-channel/12-bit instance
// share the stimulus. The reference model schedules each accepted frame as a
// list of words on absolute edge numbers and compares every output each edge.
module tb_ch_sel_seq;

  localparam int MAXE = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, strobe, clr_ovf;
  logic [7:0]  mask8;
  logic [15:0] chv [8];
  logic [63:0] din4;
  logic [95:0] din8;

  for (genvar i = 0; i < 4; i++) begin : g_d4
    assign din4[i*16 +: 16] = chv[i];
  end
  for (genvar i = 0; i < 8; i++) begin : g_d8
    assign din8[i*12 +: 12] = chv[i][11:0];
  end

  logic [1:0]  sel4;
  logic [15:0] dout4;
  logic        valid4, sof4, eof4, ovf4;
  logic [2:0]  sel8;
  logic [11:0] dout8;
  logic        valid8, sof8, eof8, ovf8;

  ch_sel_seq #(.NUM_CH(4), .DW(16)) u4 (
    .clk(clk), .reset(reset), .strobe(strobe), .ch_mask(mask8[3:0]),
    .din(din4), .clr_ovf(clr_ovf), .sel(sel4), .dout(dout4),
    .valid(valid4), .sof(sof4), .eof(eof4), .ovf(ovf4));

  ch_sel_seq #(.NUM_CH(8), .DW(12)) u8 (
    .clk(clk), .reset(reset), .strobe(strobe), .ch_mask(mask8),
    .din(din8), .clr_ovf(clr_ovf), .sel(sel8), .dout(dout8),
    .valid(valid8), .sof(sof8), .eof(eof8), .ovf(ovf8));

  // Expected outputs per instance (0: 4ch, 1: 8ch) per edge number.
  bit        mv    [2][MAXE];
  bit [3:0]  msel  [2][MAXE];
  bit [15:0] mdout [2][MAXE];
  bit        msof  [2][MAXE];
  bit        meof  [2][MAXE];
  bit        movf  [2][MAXE];
  int        fend  [2];
  bit        ovf_st[2];

  int e = 0;
  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int nch, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (ch%0d) edge %0d: observed %0h expected %0h", tag, nch, e, obs, exp);
    end
  endtask

  // Apply the rules for the edge just taken, using the inputs it sampled.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      int nch;
      int j;
      int t;
      bit over;
      logic [7:0] m;
      nch  = (d == 0) ? 4 : 8;
      m    = mask8 & 8'((1 << nch) - 1);
      over = 1'b0;
      if (reset) begin
        for (int k = e; k < e + 24 && k < MAXE; k++) begin
          mv[d][k] = 0; msel[d][k] = 0; mdout[d][k] = 0; msof[d][k] = 0; meof[d][k] = 0;
        end
        fend[d]   = -100;
        ovf_st[d] = 1'b0;
      end else begin
        if (strobe && m != 0) begin
          if (e >= fend[d]) begin
            j = 0;
            t = 0;
            for (int c = 0; c < nch; c++) begin
              if (m[c]) begin
                t = e + 2 + j;
                if (t < MAXE) begin
                  mv[d][t]    = 1'b1;
                  msel[d][t]  = 4'(c);
                  mdout[d][t] = (d == 0) ? chv[c] : {4'h0, chv[c][11:0]};
                  msof[d][t]  = (j == 0);
                  meof[d][t]  = 1'b0;
                end
                j++;
              end
            end
            if (t < MAXE) meof[d][t] = 1'b1;
            fend[d] = e + j;
          end else begin
            over = 1'b1;
          end
        end
        if (over)         ovf_st[d] = 1'b1;
        else if (clr_ovf) ovf_st[d] = 1'b0;
      end
      movf[d][e] = ovf_st[d];
    end
  endtask

  task automatic compare_edge();
    chk("valid", 4, 32'(valid4), 32'(mv[0][e]));
    chk("sel",   4, 32'(sel4),   32'(msel[0][e]));
    chk("dout",  4, 32'(dout4),  32'(mdout[0][e]));
    chk("sof",   4, 32'(sof4),   32'(msof[0][e]));
    chk("eof",   4, 32'(eof4),   32'(meof[0][e]));
    chk("ovf",   4, 32'(ovf4),   32'(movf[0][e]));
    chk("valid", 8, 32'(valid8), 32'(mv[1][e]));
    chk("sel",   8, 32'(sel8),   32'(msel[1][e]));
    chk("dout",  8, 32'(dout8),  32'(mdout[1][e]));
    chk("sof",   8, 32'(sof8),   32'(msof[1][e]));
    chk("eof",   8, 32'(eof8),   32'(meof[1][e]));
    chk("ovf",   8, 32'(ovf8),   32'(movf[1][e]));
  endtask

  task automatic step(input logic stb, input logic clr, input logic rst);
    @(negedge clk);
    strobe  = stb;
    clr_ovf = clr;
    reset   = rst;
    @(posedge clk);
    if (e >= MAXE) begin
      $display("FAIL edge_budget: observed %0d edges, limit %0d", e, MAXE);
      $fatal(1, "edge budget exhausted");
    end
    model_edge();
    #1;
    compare_edge();
    e++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic rand_ch();
    for (int i = 0; i < 8; i++) chv[i] = 16'($urandom);
  endtask

  initial begin
    strobe  = 1'b0;
    clr_ovf = 1'b0;
    reset   = 1'b1;
    mask8   = '0;
    for (int i = 0; i < 8; i++) chv[i] = '0;
    fend[0] = -100;
    fend[1] = -100;

    // Reset state.
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    idle(2);

    // Mask 1011, samples 1..4: sel 0,1,3 / dout 1,2,4.
    mask8 = 8'h0B;
    for (int i = 0; i < 8; i++) chv[i] = 16'(i + 1);
    step(1'b1, 1'b0, 1'b0);
    idle(2);
    chk("r34_first_sel",  4, 32'(sel4),  0);
    chk("r34_first_dout", 4, 32'(dout4), 1);
    chk("r34_sof",        4, 32'(sof4),  1);
    idle(2);
    chk("r34_last_sel",   4, 32'(sel4),  3);
    chk("r34_last_dout",  4, 32'(dout4), 4);
    chk("r34_eof",        4, 32'(eof4),  1);
    idle(3);

    // Single channel: sof and eof together.
    mask8 = 8'h04;
    step(1'b1, 1'b0, 1'b0);
    idle(2);
    chk("r35_valid", 4, 32'(valid4), 1);
    chk("r35_sel",   4, 32'(sel4),   2);
    chk("r35_sof",   4, 32'(sof4),   1);
    chk("r35_eof",   4, 32'(eof4),   1);
    idle(3);

    // Back-to-back frames with inputs churning mid-frame.
    mask8 = 8'h0F;
    rand_ch();
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      rand_ch();
      mask8 = 8'($urandom);
      step(1'b0, 1'b0, 1'b0);
    end
    mask8 = 8'h0F;
    rand_ch();
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      rand_ch();
      mask8 = 8'($urandom);
      step(1'b0, 1'b0, 1'b0);
    end
    chk("r36_no_ovf", 4, 32'(ovf4), 0);

    // Strobe one cycle early: overrun, frame unaffected.
    mask8 = 8'h0F;
    rand_ch();
    step(1'b1, 1'b0, 1'b0);
    idle(2);
    step(1'b1, 1'b0, 1'b0);
    idle(6);
    chk("r36_ovf_set", 4, 32'(ovf4), 1);

    // Overrun together with clear keeps the flag, then clear alone drops it.
    step(1'b1, 1'b0, 1'b0);
    idle(1);
    step(1'b1, 1'b1, 1'b0);
    idle(5);
    chk("ovf_clr_race", 4, 32'(ovf4), 1);
    step(1'b0, 1'b1, 1'b0);
    chk("ovf_cleared", 4, 32'(ovf4), 0);
    idle(1);

    // Empty mask: nothing emitted, no overrun, even mid-frame.
    mask8 = 8'h00;
    step(1'b1, 1'b0, 1'b0);
    idle(3);
    chk("r37_valid", 4, 32'(valid4), 0);
    chk("r37_ovf",   4, 32'(ovf4),   0);
    mask8 = 8'h0F;
    step(1'b1, 1'b0, 1'b0);
    idle(1);
    mask8 = 8'h00;
    step(1'b1, 1'b0, 1'b0);
    idle(5);
    chk("r37_mid_ovf", 4, 32'(ovf4), 0);

    // Reset sampled on the second word, then a strobe right after release.
    mask8 = 8'h0F;
    rand_ch();
    step(1'b1, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 1'b0, 1'b1);
    chk("r38_valid", 4, 32'(valid4), 0);
    chk("r38_eof",   4, 32'(eof4),   0);
    chk("r38_dout",  4, 32'(dout4),  0);
    mask8 = 8'h05;
    step(1'b1, 1'b0, 1'b0);
    idle(5);

    // Rate-64 strobes, random masks, samples changing every cycle.
    for (int f = 0; f < 30; f++) begin
      mask8 = 8'($urandom);
      rand_ch();
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 63; i++) begin
        mask8 = 8'($urandom);
        rand_ch();
        step(1'b0, 1'b0, 1'b0);
      end
    end
    chk("r39_ovf", 8, 32'(ovf8), 0);
    chk("r39_ovf", 4, 32'(ovf4), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
